// File: rtl/inst_fetch.sv
// Instruction fetch: PC sequencing, control-flow redirects and a 2-entry
// decode buffer in front of a single-cycle-latency instruction memory.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc4,
  input  logic        redir_valid,
  input  logic [1:0]  redir_type,
  input  logic [31:0] redir_pc4,
  input  logic [15:0] redir_imm,
  input  logic [25:0] redir_addr,
  input  logic [31:0] redir_reg,
  input  logic        halt,
  output logic        fetch_err
);

  function automatic logic [31:0] redir_target(input logic [1:0]  typ,
                                               input logic [31:0] pc4,
                                               input logic [15:0] imm,
                                               input logic [25:0] jaddr,
                                               input logic [29:0] jreg_hi);
    logic signed [31:0] off;
    logic signed [31:0] sum;
    off = $signed({{14{imm[15]}}, imm, 2'b00});
    sum = $signed(pc4) + off;
    case (typ)
      2'b00:   redir_target = $unsigned(sum);
      2'b01:   redir_target = {pc4[31:28], jaddr, 2'b00};
      default: redir_target = {jreg_hi, 2'b00};
    endcase
  endfunction

  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q;
  logic [31:0] inst_q [2];
  logic [31:0] ipc_q  [2];
  logic        rd_ptr_q, rd_ptr_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic [1:0]  count_q, count_d;
  logic        inflight_q;
  logic        discard_q;
  logic        fetch_err_q;

  logic        pop;
  logic        push;
  logic        flush;
  logic        jr_misaligned;
  logic [1:0]  occ;

  assign id_valid      = !rst && (count_q != 2'd0);
  assign id_inst       = inst_q[rd_ptr_q];
  assign id_pc         = ipc_q[rd_ptr_q];
  assign id_pc4        = id_pc + 32'd4;
  assign fetch_err     = fetch_err_q && !rst;

  assign pop           = id_valid && id_ready;
  // Reserved redirect type only blocks the request; it never flushes.
  assign flush         = redir_valid && (redir_type != 2'b11);
  assign push          = inflight_q && !discard_q && !flush;
  assign jr_misaligned = redir_valid && (redir_type == 2'b10) && (redir_reg[1:0] != 2'b00);

  // Count the outstanding response so the buffer can never overflow.
  assign occ       = count_q + {1'b0, inflight_q} - {1'b0, pop};
  assign imem_req  = !rst && !halt && !redir_valid && (occ < 2'd2);
  assign imem_addr = rst ? RESET_PC : pc_q;

  always_comb begin
    pc_d     = pc_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      pc_d     = redir_target(redir_type, redir_pc4, redir_imm, redir_addr, redir_reg[31:2]);
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (imem_req) pc_d = pc_q + 32'd4;
      if (pop)      rd_ptr_d = ~rd_ptr_q;
      if (push)     wr_ptr_d = ~wr_ptr_q;
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
      inflight_q  <= 1'b0;
      discard_q   <= 1'b0;
      fetch_err_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      inflight_q  <= imem_req;
      discard_q   <= flush;
      if (jr_misaligned) fetch_err_q <= 1'b1;
    end
  end

  // Buffer contents and request address carry no reset; occupancy guards them.
  always_ff @(posedge clk) begin
    if (push) begin
      inst_q[wr_ptr_q] <= imem_rdata;
      ipc_q[wr_ptr_q]  <= req_pc_q;
    end
    if (imem_req) req_pc_q <= pc_q;
  end

endmodule
